// File: rtl/irig_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | irig_pkg : IRIG-B frame map, BCD time type and symbol lookup          |
// | Rev 1.0  : initial release                                           |
// +----------------------------------------------------------------------+
package irig_pkg;

    localparam int FRAME_BITS   = 100;
    localparam int BIT_IDX_W    = 7;
    localparam int SEC_W        = 17;
    localparam int DAY_W        = 9;
    localparam int YEAR_W       = 7;
    localparam int SECS_PER_DAY = 86400;
    localparam int MAX_DAY      = 366;
    localparam int MAX_YEAR     = 99;

    // Field LSB positions within the 100-bit frame; markers sit at 0 and n*10+9.
    localparam int POS_PR     = 0;
    localparam int POS_SEC_U  = 1;
    localparam int POS_SEC_T  = 6;
    localparam int POS_MIN_U  = 10;
    localparam int POS_MIN_T  = 15;
    localparam int POS_HR_U   = 20;
    localparam int POS_HR_T   = 25;
    localparam int POS_DAY_U  = 30;
    localparam int POS_DAY_T  = 35;
    localparam int POS_DAY_H  = 40;
    localparam int POS_YR_U   = 50;
    localparam int POS_YR_T   = 55;
    localparam int POS_SBS_LO = 80;
    localparam int POS_SBS_HI = 90;

    typedef enum logic [1:0] {SYM_ZERO, SYM_ONE, SYM_MARK} irig_sym_t;

    typedef struct packed {
        logic [7:0]  ss;
        logic [7:0]  mm;
        logic [7:0]  hh;
        logic [11:0] ddd;
        logic [7:0]  yy;
    } bcd_time_t;

    localparam bcd_time_t BCD_EPOCH = '{ss: 8'h00, mm: 8'h00, hh: 8'h00, ddd: 12'h001, yy: 8'h00};

    function automatic logic [7:0] bcd_inc8(input logic [7:0] v);
        return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [11:0] bcd_inc12(input logic [11:0] v);
        if (v[3:0] != 4'd9)
            return {v[11:4], v[3:0] + 4'd1};
        else if (v[7:4] != 4'd9)
            return {v[11:8], v[7:4] + 4'd1, 4'd0};
        else
            return {v[11:8] + 4'd1, 8'h00};
    endfunction

    function automatic irig_sym_t irig_symbol(input logic [BIT_IDX_W-1:0] bit_idx,
                                              input bcd_time_t t,
                                              input logic [SEC_W-1:0] sbs);
        logic [FRAME_BITS-1:0] data;
        data = '0;
        data[POS_SEC_U  +: 4] = t.ss[3:0];
        data[POS_SEC_T  +: 3] = t.ss[6:4];
        data[POS_MIN_U  +: 4] = t.mm[3:0];
        data[POS_MIN_T  +: 3] = t.mm[6:4];
        data[POS_HR_U   +: 4] = t.hh[3:0];
        data[POS_HR_T   +: 2] = t.hh[5:4];
        data[POS_DAY_U  +: 4] = t.ddd[3:0];
        data[POS_DAY_T  +: 4] = t.ddd[7:4];
        data[POS_DAY_H  +: 2] = t.ddd[9:8];
        data[POS_YR_U   +: 4] = t.yy[3:0];
        data[POS_YR_T   +: 4] = t.yy[7:4];
        data[POS_SBS_LO +: 9] = sbs[8:0];
        data[POS_SBS_HI +: 8] = sbs[16:9];
        if (bit_idx == 7'(POS_PR) || (bit_idx % 7'd10) == 7'd9)
            return SYM_MARK;
        return data[bit_idx] ? SYM_ONE : SYM_ZERO;
    endfunction

endpackage
`default_nettype wire

// File: rtl/irig_bcd_time_inc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | irig_bcd_time_inc : combinational BCD + binary time step             |
// | Rev 1.0  : initial release                                           |
// +----------------------------------------------------------------------+
module irig_bcd_time_inc
    import irig_pkg::*;
(
    input  bcd_time_t          i_t,
    input  logic [SEC_W-1:0]   i_sec,
    input  logic [DAY_W-1:0]   i_day,
    input  logic [YEAR_W-1:0]  i_year,
    input  logic               i_inc_sec,
    input  logic               i_inc_day,
    input  logic               i_inc_year,
    input  logic               i_roll,
    output bcd_time_t          o_t,
    output logic [SEC_W-1:0]   o_sec,
    output logic [DAY_W-1:0]   o_day,
    output logic [YEAR_W-1:0]  o_year
);

    logic w_day_step;
    logic w_year_step;

    // With i_roll=0 each field steps independently (converter); with i_roll=1
    // second/day wraps cascade into day/year (per-second advance).
    always_comb begin
        o_t         = i_t;
        o_sec       = i_sec;
        o_day       = i_day;
        o_year      = i_year;
        w_day_step  = i_inc_day;
        w_year_step = i_inc_year;

        if (i_inc_sec) begin
            o_sec = (i_sec == 17'(SECS_PER_DAY - 1)) ? '0 : i_sec + 17'd1;
            if (i_t.ss != 8'h59) begin
                o_t.ss = bcd_inc8(i_t.ss);
            end else begin
                o_t.ss = 8'h00;
                if (i_t.mm != 8'h59) begin
                    o_t.mm = bcd_inc8(i_t.mm);
                end else begin
                    o_t.mm = 8'h00;
                    if (i_t.hh != 8'h23) begin
                        o_t.hh = bcd_inc8(i_t.hh);
                    end else begin
                        o_t.hh = 8'h00;
                        if (i_roll)
                            w_day_step = 1'b1;
                    end
                end
            end
        end

        if (w_day_step) begin
            if (i_roll && (i_t.ddd == 12'h366 ||
                           (i_t.ddd == 12'h365 && i_year[1:0] != 2'd0))) begin
                o_t.ddd = 12'h001;
                o_day   = 9'd1;
                if (i_roll)
                    w_year_step = 1'b1;
            end else begin
                o_t.ddd = bcd_inc12(i_t.ddd);
                o_day   = i_day + 9'd1;
            end
        end

        if (w_year_step) begin
            if (i_t.yy == 8'h99) begin
                o_t.yy = 8'h00;
                o_year = '0;
            end else begin
                o_t.yy = bcd_inc8(i_t.yy);
                o_year = i_year + 7'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/irig_encode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | irig_encode : IRIG-B pulse-width frame generator with local timebase |
// | Rev 1.0  : initial release                                           |
// +----------------------------------------------------------------------+
module irig_encode
    import irig_pkg::*;
#(
    parameter int CLK_HZ     = 10000000,
    parameter int BIT_CYCLES = CLK_HZ / 100,
    parameter int W_ZERO     = CLK_HZ / 500,
    parameter int W_ONE      = CLK_HZ / 200,
    parameter int W_MARK     = CLK_HZ * 8 / 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [SEC_W-1:0]   ld_sec_day,
    input  logic [DAY_W-1:0]   ld_day,
    input  logic [YEAR_W-1:0]  ld_year,
    output logic               busy,
    output logic               load_err,
    output logic               irigb,
    output logic               pps,
    output logic               tx_valid,
    output logic [SEC_W-1:0]   ts_sec_day,
    output logic [DAY_W-1:0]   ts_day,
    output logic [YEAR_W-1:0]  ts_year
);

    localparam int CW = $clog2(BIT_CYCLES);
    localparam logic [CW-1:0] C_LAST_CYC = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] C_W_ZERO   = CW'(W_ZERO);
    localparam logic [CW-1:0] C_W_ONE    = CW'(W_ONE);
    localparam logic [CW-1:0] C_W_MARK   = CW'(W_MARK);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CONV  = 2'd1;
    localparam logic [1:0] ST_READY = 2'd2;

    logic [CW-1:0]        r_cyc;
    logic [BIT_IDX_W-1:0] r_bit;
    logic                 w_last_cyc, w_frame_end;
    logic [1:0]           r_state, w_state_nxt;
    logic                 w_ld_ok, w_accept, w_conv_done;
    logic                 r_load_err, r_tx_valid;

    logic [SEC_W-1:0]     r_cnt_sec, r_conv_sec, w_conv_sec, r_sec, w_adv_sec;
    logic [DAY_W-1:0]     r_cnt_day, r_conv_day, w_conv_day, r_day, w_adv_day;
    logic [YEAR_W-1:0]    r_cnt_year, r_conv_year, w_conv_year, r_year, w_adv_year;
    bcd_time_t            r_conv, w_conv, r_frm, w_adv;
    irig_sym_t            w_sym;
    logic [CW-1:0]        w_width;

    assign w_last_cyc  = (r_cyc == C_LAST_CYC);
    assign w_frame_end = w_last_cyc && (r_bit == 7'(FRAME_BITS - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cyc <= '0;
            r_bit <= '0;
        end else if (w_last_cyc) begin
            r_cyc <= '0;
            r_bit <= (r_bit == 7'(FRAME_BITS - 1)) ? '0 : r_bit + 7'd1;
        end else begin
            r_cyc <= r_cyc + CW'(1);
        end
    end

    assign w_ld_ok = (ld_sec_day <= 17'(SECS_PER_DAY - 1)) && (ld_day != '0) &&
                     (ld_day <= 9'(MAX_DAY)) && (ld_year <= 7'(MAX_YEAR));
    assign w_accept    = load && !busy && w_ld_ok;
    assign w_conv_done = (r_cnt_sec == '0) && (r_cnt_day == '0) && (r_cnt_year == '0);

    always_ff @(posedge clk) begin
        if (!rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept)    w_state_nxt = ST_CONV;
            ST_CONV:  if (w_conv_done) w_state_nxt = ST_READY;
            ST_READY: if (w_frame_end) w_state_nxt = ST_IDLE;
            default:                   w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != ST_IDLE);
    end

    irig_bcd_time_inc u_conv_step (
        .i_t        (r_conv),
        .i_sec      (r_conv_sec),
        .i_day      (r_conv_day),
        .i_year     (r_conv_year),
        .i_inc_sec  (r_cnt_sec != '0),
        .i_inc_day  (r_cnt_day != '0),
        .i_inc_year (r_cnt_year != '0),
        .i_roll     (1'b0),
        .o_t        (w_conv),
        .o_sec      (w_conv_sec),
        .o_day      (w_conv_day),
        .o_year     (w_conv_year)
    );

    irig_bcd_time_inc u_advance (
        .i_t        (r_frm),
        .i_sec      (r_sec),
        .i_day      (r_day),
        .i_year     (r_year),
        .i_inc_sec  (1'b1),
        .i_inc_day  (1'b0),
        .i_inc_year (1'b0),
        .i_roll     (1'b1),
        .o_t        (w_adv),
        .o_sec      (w_adv_sec),
        .o_day      (w_adv_day),
        .o_year     (w_adv_year)
    );

    // Binary down-counters drain into BCD up-counters; binary copies climb alongside.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt_sec   <= '0;
            r_cnt_day   <= '0;
            r_cnt_year  <= '0;
            r_conv      <= '0;
            r_conv_sec  <= '0;
            r_conv_day  <= '0;
            r_conv_year <= '0;
        end else if (w_accept) begin
            r_cnt_sec   <= ld_sec_day;
            r_cnt_day   <= ld_day - 9'd1;
            r_cnt_year  <= ld_year;
            r_conv      <= BCD_EPOCH;
            r_conv_sec  <= '0;
            r_conv_day  <= 9'd1;
            r_conv_year <= '0;
        end else if (r_state == ST_CONV) begin
            if (r_cnt_sec != '0)  r_cnt_sec  <= r_cnt_sec - 17'd1;
            if (r_cnt_day != '0)  r_cnt_day  <= r_cnt_day - 9'd1;
            if (r_cnt_year != '0) r_cnt_year <= r_cnt_year - 7'd1;
            r_conv      <= w_conv;
            r_conv_sec  <= w_conv_sec;
            r_conv_day  <= w_conv_day;
            r_conv_year <= w_conv_year;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_frm      <= '0;
            r_sec      <= '0;
            r_day      <= '0;
            r_year     <= '0;
            r_tx_valid <= 1'b0;
        end else if (w_frame_end) begin
            if (r_state == ST_READY) begin
                r_frm      <= r_conv;
                r_sec      <= r_conv_sec;
                r_day      <= r_conv_day;
                r_year     <= r_conv_year;
                r_tx_valid <= 1'b1;
            end else if (r_tx_valid) begin
                r_frm  <= w_adv;
                r_sec  <= w_adv_sec;
                r_day  <= w_adv_day;
                r_year <= w_adv_year;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            r_load_err <= 1'b0;
        else
            r_load_err <= load && (busy || !w_ld_ok);
    end

    always_comb begin
        w_sym = irig_symbol(r_bit, r_frm, r_sec);
        case (w_sym)
            SYM_MARK: w_width = C_W_MARK;
            SYM_ONE:  w_width = C_W_ONE;
            default:  w_width = C_W_ZERO;
        endcase
    end

    // Gating pps with rst keeps it low while reset is held, yet lets cycle 0 pulse.
    assign pps        = rst && (r_bit == '0) && (r_cyc == '0);
    assign irigb      = r_tx_valid && (r_cyc < w_width);
    assign load_err   = r_load_err;
    assign tx_valid   = r_tx_valid;
    assign ts_sec_day = r_sec;
    assign ts_day     = r_day;
    assign ts_year    = r_year;

endmodule
`default_nettype wire

// File: tb/tb_irig_encode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_irig_encode : directed bench for irig_encode at a scaled clock    |
// | Rev 1.0  : initial release                                           |
// +----------------------------------------------------------------------+
module tb_irig_encode;
    import irig_pkg::*;

    localparam int CLK_HZ    = 10000;
    localparam int BIT_CYC   = CLK_HZ / 100;
    localparam int FRAME_CYC = BIT_CYC * 100;

    logic        clk = 1'b0;
    logic        rst, load;
    logic [16:0] ld_sec_day;
    logic [8:0]  ld_day;
    logic [6:0]  ld_year;
    logic        busy, load_err, irigb, pps, tx_valid;
    logic [16:0] ts_sec_day;
    logic [8:0]  ts_day;
    logic [6:0]  ts_year;

    bcd_time_t   inc_t_in, inc_t_out;
    logic [16:0] inc_sec_in, inc_sec_out;
    logic [8:0]  inc_day_in, inc_day_out;
    logic [6:0]  inc_year_in, inc_year_out;

    int n_checks = 0;
    int n_pass   = 0;
    int t        = 0;
    int hi [100];
    int pps_cnt, hi_total;

    always #5 clk = ~clk;

    irig_encode #(.CLK_HZ(CLK_HZ)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .ld_sec_day (ld_sec_day),
        .ld_day     (ld_day),
        .ld_year    (ld_year),
        .busy       (busy),
        .load_err   (load_err),
        .irigb      (irigb),
        .pps        (pps),
        .tx_valid   (tx_valid),
        .ts_sec_day (ts_sec_day),
        .ts_day     (ts_day),
        .ts_year    (ts_year)
    );

    irig_bcd_time_inc u_inc (
        .i_t        (inc_t_in),
        .i_sec      (inc_sec_in),
        .i_day      (inc_day_in),
        .i_year     (inc_year_in),
        .i_inc_sec  (1'b1),
        .i_inc_day  (1'b0),
        .i_inc_year (1'b0),
        .i_roll     (1'b1),
        .o_t        (inc_t_out),
        .o_sec      (inc_sec_out),
        .o_day      (inc_day_out),
        .o_year     (inc_year_out)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic run_to(input int target);
        while (t < target) tick();
    endtask

    task automatic scan_frame();
        for (int b = 0; b < 100; b++) hi[b] = 0;
        pps_cnt  = 0;
        hi_total = 0;
        for (int c = 0; c < FRAME_CYC; c++) begin
            if (irigb) begin
                hi[c / BIT_CYC]++;
                hi_total++;
            end
            if (pps) pps_cnt++;
            tick();
        end
    endtask

    task automatic do_load(input logic [16:0] s, input logic [8:0] d, input logic [6:0] y);
        ld_sec_day = s;
        ld_day     = d;
        ld_year    = y;
        load       = 1'b1;
        tick();
        load       = 1'b0;
    endtask

    task automatic inc_case(input string tag, input bcd_time_t ti, input int s, input int d, input int y,
                            input bcd_time_t te, input int es, input int ed, input int ey);
        inc_t_in    = ti;
        inc_sec_in  = 17'(s);
        inc_day_in  = 9'(d);
        inc_year_in = 7'(y);
        #1;
        check({tag, "_bcd"},  64'(inc_t_out),    64'(te));
        check({tag, "_sec"},  64'(inc_sec_out),  64'(es));
        check({tag, "_day"},  64'(inc_day_out),  64'(ed));
        check({tag, "_year"}, 64'(inc_year_out), 64'(ey));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Frame 2 carries 01:02:05 (3725 s), day 123, year 24: data-1 bit positions.
        int          f2_ones [17] = '{1, 3, 11, 20, 30, 31, 36, 40, 52, 56, 80, 82, 83, 87, 90, 91, 92};
        logic [99:0] f2_map;
        int          exp_w;
        f2_map = '0;
        foreach (f2_ones[i]) f2_map[f2_ones[i]] = 1'b1;

        inc_case("inc_noleap", '{ss: 8'h59, mm: 8'h59, hh: 8'h23, ddd: 12'h365, yy: 8'h23}, 86399, 365, 23,
                 '{ss: 8'h00, mm: 8'h00, hh: 8'h00, ddd: 12'h001, yy: 8'h24}, 0, 1, 24);
        inc_case("inc_leap365", '{ss: 8'h59, mm: 8'h59, hh: 8'h23, ddd: 12'h365, yy: 8'h24}, 86399, 365, 24,
                 '{ss: 8'h00, mm: 8'h00, hh: 8'h00, ddd: 12'h366, yy: 8'h24}, 0, 366, 24);
        inc_case("inc_yr99", '{ss: 8'h59, mm: 8'h59, hh: 8'h23, ddd: 12'h366, yy: 8'h99}, 86399, 366, 99,
                 '{ss: 8'h00, mm: 8'h00, hh: 8'h00, ddd: 12'h001, yy: 8'h00}, 0, 1, 0);
        inc_case("inc_min", '{ss: 8'h59, mm: 8'h01, hh: 8'h00, ddd: 12'h001, yy: 8'h00}, 119, 1, 0,
                 '{ss: 8'h00, mm: 8'h02, hh: 8'h00, ddd: 12'h001, yy: 8'h00}, 120, 1, 0);

        rst = 1'b0; load = 1'b0; ld_sec_day = '0; ld_day = '0; ld_year = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pps", 64'(pps), 64'(0));
        check("rst_irigb", 64'(irigb), 64'(0));
        check("rst_tx_valid", 64'(tx_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_load_err", 64'(load_err), 64'(0));
        check("rst_ts_sec", 64'(ts_sec_day), 64'(0));

        rst = 1'b1;
        t   = 0;
        #1;
        check("pps_cycle0", 64'(pps), 64'(1));
        scan_frame();
        check("f0_irigb_quiet", 64'(hi_total), 64'(0));
        check("f0_pps_count", 64'(pps_cnt), 64'(1));
        check("f1_pps", 64'(pps), 64'(1));
        check("f1_tx_valid", 64'(tx_valid), 64'(0));

        do_load(17'd3725, 9'd123, 7'd24);
        check("load_ok_err", 64'(load_err), 64'(0));
        check("load_busy", 64'(busy), 64'(1));
        run_to(FRAME_CYC + 5);
        do_load(17'd500, 9'd1, 7'd0);
        check("busy_load_err", 64'(load_err), 64'(1));
        tick();
        check("load_err_pulse", 64'(load_err), 64'(0));

        run_to(FRAME_CYC * 2 - 1000);
        check("ready_busy", 64'(busy), 64'(1));
        check("ready_no_tx", 64'(tx_valid), 64'(0));

        run_to(FRAME_CYC * 2);
        check("f2_pps", 64'(pps), 64'(1));
        check("f2_tx_valid", 64'(tx_valid), 64'(1));
        check("f2_busy", 64'(busy), 64'(0));
        check("f2_ts_sec", 64'(ts_sec_day), 64'(3725));
        check("f2_ts_day", 64'(ts_day), 64'(123));
        check("f2_ts_year", 64'(ts_year), 64'(24));
        scan_frame();
        for (int b = 0; b < 100; b++) begin
            exp_w = (b == 0 || b % 10 == 9) ? 80 : (f2_map[b] ? 50 : 20);
            check($sformatf("f2_bit%0d", b), 64'(hi[b]), 64'(exp_w));
        end
        check("f2_pps_count", 64'(pps_cnt), 64'(1));

        check("f3_ts_sec", 64'(ts_sec_day), 64'(3726));
        check("f3_ts_day", 64'(ts_day), 64'(123));
        scan_frame();
        check("f3_bit1", 64'(hi[1]), 64'(20));
        check("f3_bit2", 64'(hi[2]), 64'(50));
        check("f3_bit80", 64'(hi[80]), 64'(20));
        check("f3_bit81", 64'(hi[81]), 64'(50));

        check("f4_ts_sec", 64'(ts_sec_day), 64'(3727));
        do_load(17'd86400, 9'd1, 7'd0);
        check("bad_sec_err", 64'(load_err), 64'(1));
        check("bad_sec_busy", 64'(busy), 64'(0));
        do_load(17'd100, 9'd0, 7'd0);
        check("bad_day0_err", 64'(load_err), 64'(1));
        do_load(17'd100, 9'd367, 7'd0);
        check("bad_day367_err", 64'(load_err), 64'(1));
        do_load(17'd100, 9'd1, 7'd100);
        check("bad_year_err", 64'(load_err), 64'(1));
        check("bad_year_busy", 64'(busy), 64'(0));

        do_load(17'd200, 9'd1, 7'd0);
        check("mid_load_busy", 64'(busy), 64'(1));
        run_to(FRAME_CYC * 4 + 100);
        rst = 1'b0;
        tick();
        tick();
        check("mid_rst_tx_valid", 64'(tx_valid), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_irigb", 64'(irigb), 64'(0));
        check("mid_rst_pps", 64'(pps), 64'(0));
        check("mid_rst_ts", 64'(ts_sec_day), 64'(0));

        rst = 1'b1;
        t   = 0;
        #1;
        check("re_pps_cycle0", 64'(pps), 64'(1));
        scan_frame();
        check("re_irigb_quiet", 64'(hi_total), 64'(0));
        check("re_tx_valid", 64'(tx_valid), 64'(0));
        check("re_busy", 64'(busy), 64'(0));
        check("re_pps", 64'(pps), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/irig_encode.md
Name: irig_encode

Overview:
- IRIG-B (unmodulated, pulse-width) frame generator. It is the transmit counterpart of the irig receiver chain and produces a 100 bit/s stream on a 10 MHz clock.
- The host loads binary time (seconds-of-day, day, year). The block converts it to BCD, then transmits one frame per second and advances time autonomously.
- It emits a one-cycle pps aligned to each Pr marker. It is used for loopback test of the irig receiver and as a local time master.

Parameters:
- CLK_HZ, 10000000, input clock frequency.
- BIT_CYCLES, CLK_HZ/100, clocks per IRIG bit (100000).
- W_ZERO, CLK_HZ/500, high time for a "0" bit (2 ms, 20000).
- W_ONE, CLK_HZ/200, high time for a "1" bit (5 ms, 50000).
- W_MARK, CLK_HZ*8/1000, high time for a marker (8 ms, 80000).

Ports:
- clk  in  1  10 MHz clock.
- rst  in  1  synchronous, active-low reset.
- load  in  1  one-cycle strobe; captures ld_* when busy=0.
- ld_sec_day  in  17  seconds of day, 0..86399.
- ld_day  in  9  day of year, 1..366.
- ld_year  in  7  two-digit year, 0..99.
- busy  out  1  conversion in progress.
- load_err  out  1  one-cycle pulse when load is rejected.
- irigb  out  1  IRIG-B pulse-width output.
- pps  out  1  one-cycle pulse at the start of bit 0 of every frame.
- tx_valid  out  1  frames carry loaded time.
- ts_sec_day  out  17  time of the frame currently transmitted.
- ts_day  out  9  day of the frame currently transmitted.
- ts_year  out  7  year of the frame currently transmitted.

Behaviour:
- Reset (rst=0 at clk edge): all outputs 0; timebase at bit 0, cycle 0; no pending load. The timebase runs free from reset release.
- Timebase:
  - cyc counts 0..BIT_CYCLES-1; bit counts 0..99 and wraps to 0.
  - pps=1 exactly when bit=0 and cyc=0, every frame, regardless of tx_valid.
- Bit encoding:
  - irigb=1 while cyc<W(bit), else 0.
  - W = W_MARK for bits 0, 9, 19, ..., 99; W_ONE for a data bit equal to 1; W_ZERO otherwise.
  - irigb is held 0 while tx_valid=0.
- Frame map (BCD, LSB first):
  - Seconds: units 1-4, tens 6-8.
  - Minutes: units 10-13, tens 15-17.
  - Hours: units 20-23, tens 25-26.
  - Day: units 30-33, tens 35-38, hundreds 40-41.
  - Year: units 50-53, tens 55-58.
  - Straight binary seconds: bits 0-8 of sec_day at frame bits 80-88, bits 9-16 at 90-97.
  - Index bits and control bits 60-79 are 0.
- Load validation:
  - A load with busy=0 and ld_sec_day<=86399, 1<=ld_day<=366, ld_year<=99 is accepted.
  - Otherwise, or if busy=1, load_err pulses the next cycle and the load is ignored.
- Conversion FSM (IDLE -> CONV -> READY):
  - CONV zeroes the BCD registers, then each cycle decrements every nonzero binary down-counter and increments the matching BCD counter.
  - The BCD seconds counter carries through ss/mm/hh.
  - The day counter starts at ld_day-1 from BCD 001.
  - CONV ends when all counters are 0; worst case 86400 cycles, under 8.7 ms.
  - busy=1 in CONV and READY.
- Apply:
  - On the cycle bit=99, cyc=BIT_CYCLES-1, a READY result is copied into the frame registers, tx_valid is set, and the FSM returns to IDLE.
  - A load accepted during the first 990 ms after pps is therefore transmitted in the next frame.
- Advance: at the same boundary with no READY result and tx_valid=1, time increments by 1 s.
  - sec_day 86399 -> 0 with day+1.
  - Day 365 -> 1 on a non-leap year; day 366 -> 1 on a leap year (year%4==0). Either wrap increments year.
  - Year 99 -> 0.
  - BCD and binary copies always change together.
- Frame contents and ts_* outputs change only at the frame boundary; the ts_* change is visible with the pps cycle.
- A reset mid-frame or mid-conversion aborts immediately and clears tx_valid and any pending result.

Decomposition:
- irig_pkg holds the following; the receiver chain shares the frame-map constants.
  - Width, bit-count and marker position constants.
  - Frame field bit positions.
  - SECS_PER_DAY = 86400.
  - A struct for the BCD time {ss, mm, hh, ddd, yy}.
  - A function mapping (bit index, time struct) to symbol {ZERO, ONE, MARK}.
- Sub-module irig_bcd_time_inc: combinational one-second BCD and binary increment with day/year/leap rollover. It is shared by the converter steps and the per-second advance.

Test Plan:
- Reset, no load, run 2 s -> irigb=0 throughout; pps pulses at cycles 0 and 10,000,000; tx_valid=0.
- Load 45296 (12:34:56), day 123, year 24 right after pps -> next frame bit 0 high 80000 cycles; bit 1 (sec units 6, LSB 0) high 20000; bit 2 high 50000; bits 80-97 encode 45296; ts_sec_day=45296 at pps.
- Load 86399, day 365, year 23; run 2 frames -> second frame time is 0, day 1, year 24; all BCD fields are zero except day=001 and year=24.
- Load 86399, day 365, year 24 (leap) -> next frame day 366, year 24; then 86399/366/99 -> day 1, year 0.
- Load with ld_sec_day=86400, ld_day=0, or while busy=1 -> load_err pulse; transmitted time unchanged.
- Loopback irigb into the irig receiver for 5 frames; assert rst=0 mid-frame -> receiver timestamps match ts_* each second; after reset, irigb=0 and tx_valid=0 until reload.
